// File: rtl/mdu_seq_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide sequencer.
package mdu_seq_pkg;

  // M-extension funct3 encodings
  localparam logic [2:0] MUL_FUNCT3    = 3'b000;
  localparam logic [2:0] MULH_FUNCT3   = 3'b001;
  localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
  localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
  localparam logic [2:0] DIV_FUNCT3    = 3'b100;
  localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
  localparam logic [2:0] REM_FUNCT3    = 3'b110;
  localparam logic [2:0] REMU_FUNCT3   = 3'b111;

  // funct7 that the decoder uses to route an OP instruction to this unit
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == MUL_FUNCT3) || (f3 == MULH_FUNCT3) || (f3 == MULHSU_FUNCT3) ||
           (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV and REM
  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == MUL_FUNCT3) || (f3 == MULH_FUNCT3) ||
           (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
  endfunction

endpackage

// File: rtl/mdu_seq_iter_step.sv
// One radix-2 iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
module mdu_iter_step
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  step_mode_e          mode,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opnd_i,
  output logic [2*XLEN-1:0]   acc_o,
  output logic                q_bit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   hi_s;
  logic [XLEN-1:0] trial;
  logic            ge;

  // Compute both step flavours and select by mode
  always_comb begin
    sum     = '0;
    hi_s    = '0;
    trial   = '0;
    ge      = 1'b0;
    acc_o   = acc_i;
    q_bit_o = 1'b0;
    if (mode == STEP_MUL) begin
      // add multiplicand on multiplier LSB, then shift the whole product right
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      // shift {rem, dividend} left, trial-subtract the divisor from the remainder
      hi_s    = acc_i[2*XLEN-1:XLEN-1];
      ge      = (hi_s >= {1'b0, opnd_i});
      trial   = hi_s[XLEN-1:0] - opnd_i;
      q_bit_o = ge;
      acc_o   = {(ge ? trial : hi_s[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// RV32M iterative multiply/divide sequencer with fast path and valid/ready result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MDU_IDLE | ready for a new op; corner cases jump straight to DONE
// MDU_CALC | one shift-add / restoring-divide iteration per cycle
// MDU_FIX  | sign correction and result-half selection
// MDU_DONE | result held on out_valid until out_ready (or flush)
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  step_mode_e        step_mode;
  logic [2*XLEN-1:0] step_acc;
  logic              step_q_bit;

  logic              accept;
  logic              is_div;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, mul_zero;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign step_mode = funct3_q[2] ? STEP_DIV : STEP_MUL;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .mode    (step_mode),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q_bit)
  );

  // Operand conditioning and corner-case detection for the op on the input port
  always_comb begin
    is_div   = funct3[2];
    sign_a   = rs1_is_signed(funct3) & rs1[XLEN-1];
    sign_b   = rs2_is_signed(funct3) & rs2[XLEN-1];
    abs_a    = sign_a ? -rs1 : rs1;
    abs_b    = sign_b ? -rs2 : rs2;
    div_zero = is_div & (rs2 == '0);
    div_ovf  = is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    mul_zero = ~is_div & ((rs1 == '0) | (rs2 == '0));
    fast_res = '0;
    if (div_zero)     fast_res = funct3[1] ? rs1 : '1;
    else if (div_ovf) fast_res = funct3[1] ? '0 : MIN_NEG;
  end

  // Sign correction of the finished magnitude results
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    funct3_d  = funct3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    accept    = 1'b0;

    in_ready  = (state_q == MDU_IDLE);
    out_valid = (state_q == MDU_DONE);
    result    = result_q;
    stall     = in_valid & ~flush & ~((state_q == MDU_DONE) & out_ready);

    case (state_q)
      MDU_IDLE: begin
        accept = in_valid & ~flush;
        if (accept) begin
          funct3_d  = funct3;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          acc_d     = is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
          opnd_d    = is_div ? abs_b : abs_a;
          if (div_zero | div_ovf | mul_zero) begin
            result_d = fast_res;
            state_d  = MDU_DONE;
          end else begin
            state_d  = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_d = step_acc;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = MDU_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MDU_FIX: begin
        if (funct3_q[2])              result_d = funct3_q[1] ? rem_fix : quot_fix;
        else if (funct3_q[1:0] == 2'b00) result_d = prod_fix[XLEN-1:0];
        else                          result_d = prod_fix[2*XLEN-1:XLEN];
        state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (out_ready) begin
          result_d = '0;
          state_d  = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    // flush wins over everything, including a pending result handshake
    if (flush) begin
      state_d  = MDU_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      funct3_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      funct3_q  <= funct3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // the quotient bit is also folded into the accumulator; the port is kept for
  // other users of the step block
  logic unused_q_bit;
  assign unused_q_bit = step_q_bit;

endmodule
